// File: rtl/bch31_pkg.sv
// GF(2^5) helpers for the BCH(31,k) syndrome front end (x^5+x^2+1).
// The multiply-by-alpha^j matrices are built at elaboration, so only XOR trees remain.
package bch31_pkg;
  localparam int N = 31;
  localparam int M = 5;
  localparam logic [M-1:0] PRIM_POLY = 5'b00101;

  typedef logic [M-1:0] gf_elem_t;
  // m[c] is the image of basis element x^c, i.e. column c of the matrix
  typedef logic [M-1:0][M-1:0] gf_mat_t;

  function automatic gf_elem_t gf_mul_alpha(gf_elem_t a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY : '0);
  endfunction

  function automatic gf_mat_t gf_alpha_pow_mat(int j);
    gf_mat_t  m;
    gf_elem_t v;
    for (int c = 0; c < M; c++) begin
      v = gf_elem_t'(1) << c;
      for (int k = 0; k < (j % N); k++) v = gf_mul_alpha(v);
      m[c] = v;
    end
    return m;
  endfunction

  function automatic gf_elem_t gf_mat_mul(gf_mat_t m, gf_elem_t a);
    gf_elem_t r;
    r = '0;
    for (int c = 0; c < M; c++) if (a[c]) r ^= m[c];
    return r;
  endfunction
endpackage

// File: rtl/bch31_syn_cell.sv
// One syndrome accumulator A_J with its constant alpha^J Horner multiplier.
module bch31_syn_cell
  import bch31_pkg::*;
#(
  parameter int J = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     step,
  input  logic     in_bit,
  output gf_elem_t acc_d
);
  localparam gf_mat_t MUL_MAT = gf_alpha_pow_mat(J);

  gf_elem_t acc_q;

  always_comb begin
    acc_d = acc_q;
    if (load)      acc_d = {{(M-1){1'b0}}, in_bit};
    else if (step) acc_d = gf_mat_mul(MUL_MAT, acc_q) ^ {{(M-1){1'b0}}, in_bit};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end
endmodule

// File: rtl/bch31_syndrome.sv
// Serial BCH(31,k) syndrome calculator: one bit per cycle, r_30 first,
// emits S_1..S_2T with a one-cycle valid pulse after r_0 is accepted.
module bch31_syndrome
  import bch31_pkg::*;
#(
  parameter int T = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_bit,
  input  logic                  in_sof,
  output logic                  busy,
  output logic [2*T-1:0][M-1:0] syn,
  output logic                  syn_valid,
  output logic                  syn_zero,
  output logic                  frame_err
);
  localparam int NS = 2 * T;

  logic [NS-1:0][M-1:0] acc_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [NS-1:0][M-1:0] syn_q, syn_d;
  logic                 syn_valid_q, syn_valid_d;
  logic                 syn_zero_q, syn_zero_d;
  logic                 frame_err_q, frame_err_d;
  logic                 load, step, last;

  // sof always wins: it restarts the frame whether or not one is in flight
  assign load = in_valid & in_sof;
  assign step = in_valid & ~in_sof & busy_q;
  assign last = step & (cnt_q == 5'(N-1));

  for (genvar g = 0; g < NS; g++) begin : g_cell
    bch31_syn_cell #(.J(g + 1)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .in_bit (in_bit),
      .acc_d  (acc_d[g])
    );
  end

  always_comb begin
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    syn_d       = syn_q;
    syn_zero_d  = syn_zero_q;
    syn_valid_d = last;
    frame_err_d = load & busy_q;
    if (load) begin
      cnt_d  = 5'd1;
      busy_d = 1'b1;
    end else if (last) begin
      // capture the post-update accumulators so r_0 is included
      cnt_d      = '0;
      busy_d     = 1'b0;
      syn_d      = acc_d;
      syn_zero_d = (acc_d == '0);
    end else if (step) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      syn_q       <= '0;
      syn_valid_q <= 1'b0;
      syn_zero_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      syn_q       <= syn_d;
      syn_valid_q <= syn_valid_d;
      syn_zero_q  <= syn_zero_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign busy      = busy_q;
  assign syn       = syn_q;
  assign syn_valid = syn_valid_q;
  assign syn_zero  = syn_zero_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_bch31_syndrome.sv
// Bench for bch31_syndrome: directed and random codewords against a
// power-sum syndrome model (S_j = XOR of alpha^(i*j) over set bits r_i).
module tb_bch31_syndrome;
  localparam int T = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_bit = 1'b0;
  logic            in_sof = 1'b0;
  logic            busy;
  logic [5:0][4:0] syn;
  logic            syn_valid;
  logic            syn_zero;
  logic            frame_err;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int vld_cnt = 0;
  logic [29:0] vq_syn[$];
  logic        vq_zero[$];
  int          vq_cyc[$];

  bch31_syndrome #(.T(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .busy      (busy),
    .syn       (syn),
    .syn_valid (syn_valid),
    .syn_zero  (syn_zero),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (syn_valid) begin
      vld_cnt++;
      vq_syn.push_back(syn);
      vq_zero.push_back(syn_zero);
      vq_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
  end

  function automatic logic [29:0] model_syn(logic [30:0] cw);
    int          e[31];
    int          v;
    int          s;
    logic [29:0] r;
    v = 1;
    for (int k = 0; k < 31; k++) begin
      e[k] = v;
      v = v * 2;
      if (v >= 32) v = v ^ 37;
    end
    r = '0;
    for (int j = 1; j <= 2 * T; j++) begin
      s = 0;
      for (int i = 0; i < 31; i++) if (cw[i]) s = s ^ e[(i * j) % 31];
      r[(j-1)*5 +: 5] = 5'(s);
    end
    return r;
  endfunction

  function automatic logic [29:0] pack6(int s1, int s2, int s3, int s4, int s5, int s6);
    return {5'(s6), 5'(s5), 5'(s4), 5'(s3), 5'(s2), 5'(s1)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_bits(logic [30:0] cw, int hi, int lo, int gap_pct, bit sof_first);
    for (int i = hi; i >= lo; i--) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof_first && (i == hi);
      in_bit   = cw[i];
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_bit   = 1'b0;
    end
  endtask

  task automatic expect_frame(string tag, logic [30:0] cw, output int c);
    int          w;
    logic [29:0] s;
    logic        z;
    w = 0;
    c = -1;
    while (vq_syn.size() == 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (vq_syn.size() == 0) begin
      chk_cnt++;
      $error("FAIL %s_timeout observed=no syn_valid expected=syn_valid pulse", tag);
    end else begin
      s = vq_syn.pop_front();
      z = vq_zero.pop_front();
      c = vq_cyc.pop_front();
      chk({tag, "_syn"}, 64'(s), 64'(model_syn(cw)));
      chk({tag, "_zero"}, 64'(z), 64'(model_syn(cw) == '0));
    end
  endtask

  initial begin
    logic [30:0] cw;
    logic [30:0] cw2;
    int          c1, c2, v0;

    // reset state
    idle(2);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_syn", 64'(syn), 0);
    chk("rst_valid", 64'(syn_valid), 0);
    chk("rst_zero", 64'(syn_zero), 0);
    chk("rst_ferr", 64'(frame_err), 0);
    rst = 1'b1;

    // non-sof bits while idle are dropped
    send_bits(31'h7fffffff, 30, 28, 0, 1'b0);
    idle(2);
    chk("stray_busy", 64'(busy), 0);
    chk("stray_novalid", 64'(vld_cnt), 0);

    // all-zero codeword, gapless: latency and pulse width
    send_bits('0, 30, 0, 0, 1'b1);
    idle(1);
    chk("zero_valid_lat", 64'(syn_valid), 1);
    chk("zero_busy_drop", 64'(busy), 0);
    chk("zero_syn", 64'(syn), 0);
    chk("zero_flag", 64'(syn_zero), 1);
    idle(1);
    chk("zero_valid_pulse", 64'(syn_valid), 0);
    expect_frame("zero", '0, c1);

    // single 1 at r_0
    cw = 31'h1;
    send_bits(cw, 30, 0, 0, 1'b1);
    idle(1);
    chk("r0_const", 64'(syn), 64'(pack6(1, 1, 1, 1, 1, 1)));
    chk("r0_zero", 64'(syn_zero), 0);
    expect_frame("r0", cw, c1);

    // r_30 then r_1 back to back
    cw  = 31'h40000000;
    cw2 = 31'h2;
    send_bits(cw, 30, 0, 0, 1'b1);
    send_bits(cw2, 30, 0, 0, 1'b1);
    idle(1);
    chk("r1_const", 64'(syn), 64'(pack6(2, 4, 8, 16, 5, 10)));
    expect_frame("r30", cw, c1);
    chk("r30_const", 64'(model_syn(cw)), 64'(pack6(18, 9, 22, 11, 23, 25)));
    expect_frame("r1", cw2, c2);
    chk("b2b_spacing", 64'(c2 - c1), 31);
    chk("b2b_no_ferr", 64'(ferr_cnt), 0);

    // sof mid-frame at bit 10 abandons the old frame
    cw  = 31'($urandom);
    cw2 = 31'($urandom);
    send_bits(cw, 30, 21, 0, 1'b1);
    idle(1);
    chk("mid_busy", 64'(busy), 1);
    v0 = vld_cnt;
    send_bits(cw2, 30, 0, 0, 1'b1);
    idle(2);
    chk("ferr_once", 64'(ferr_cnt), 1);
    chk("ferr_one_valid", 64'(vld_cnt - v0), 1);
    expect_frame("restart", cw2, c1);

    // random codewords with in_valid gaps
    for (int f = 0; f < 4; f++) begin
      cw = 31'($urandom);
      send_bits(cw, 30, 0, 30, 1'b1);
      idle(1);
      expect_frame($sformatf("rand%0d", f), cw, c1);
    end
    chk("rand_no_ferr", 64'(ferr_cnt), 1);

    // asynchronous reset in the middle of a frame
    cw = 31'($urandom) | 31'h1;
    send_bits(cw, 30, 16, 25, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_syn", 64'(syn), 0);
    chk("arst_zero", 64'(syn_zero), 0);
    chk("arst_valid", 64'(syn_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    v0 = vld_cnt;
    send_bits(cw, 15, 0, 25, 1'b0);
    idle(40);
    chk("arst_no_valid", 64'(vld_cnt - v0), 0);
    chk("arst_idle_busy", 64'(busy), 0);

    // normal operation after the abort
    cw = 31'($urandom);
    send_bits(cw, 30, 0, 10, 1'b1);
    idle(1);
    expect_frame("post_rst", cw, c1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=bench completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bch31_syndrome.md
# bch31_syndrome

Serial syndrome calculator for the BCH(31,k) decoder over GF(2^5) with primitive polynomial x^5+x^2+1. It accepts a received 31-bit codeword one bit per cycle, highest-degree coefficient first, and evaluates r(α^j) for j = 1..2T. It sits directly upstream of the GF-arithmetic/key-equation stage and hands it a registered syndrome vector with a one-cycle valid pulse.

## Interface
- T, default 3: error-correction capability; 2T syndromes are computed (legal range 1..7).
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit (and in_sof) are valid this cycle.
- in_bit  input  1  received coefficient r_i; r_30 first, r_0 last.
- in_sof  input  1  qualifies in_bit as r_30 (first bit of a codeword).
- busy  output  1  frame in progress (1..30 bits accepted).
- syn  output  2T×5  packed syndromes; syn[j-1] = S_j = r(α^j).
- syn_valid  output  1  one-cycle pulse; syn and syn_zero are updated.
- syn_zero  output  1  all 2T syndromes are zero (no detectable error).
- frame_err  output  1  one-cycle pulse; in_sof arrived mid-frame.

## Operation
- Accumulators A_j (5 bits, j = 1..2T), bit counter cnt (5 bits, 0..30), and a busy flag.
- Horner update on each accepted bit: A_j ← (A_j · α^j) ⊕ {4'b0, in_bit}. The constant multiply is a fixed XOR network reduced modulo x^5+x^2+1.
- Accept rule: a bit is accepted when in_valid=1 and either in_sof=1 or busy=1. If in_valid=1, in_sof=0 and the block is idle, the bit is dropped silently.
- Bit with in_sof=1:
  - A_j is loaded with {4'b0, in_bit}, discarding the previous contents.
  - cnt ← 1, busy ← 1.
  - If busy was already 1, frame_err pulses the next cycle and the partial frame is abandoned.
- Bit with in_sof=0 while busy: the Horner update is applied and cnt increments.
- 31st accepted bit (cnt == 30 at acceptance):
  - syn ← final A_j values.
  - syn_zero ← (all final A_j == 0).
  - syn_valid pulses; busy ← 0; cnt ← 0.
- Back-to-back frames: a new in_sof bit is legal in the cycle right after the 31st bit. There is no gap and no frame_err.
- in_valid=0 stalls the block with no state change; gaps inside a frame are allowed.
- syn and syn_zero hold their values until the next completed frame. Abandoned frames never update them.
- Reset (asynchronous, any time, including mid-frame):
  - syn = 0, syn_zero = 0, syn_valid = 0, frame_err = 0, busy = 0.
  - cnt = 0, all A_j = 0.
  - The partial frame is discarded.

## Timing
- Throughput: 1 bit/cycle; 31 cycles per codeword minimum.
- Latency: syn_valid is asserted in the cycle after the edge that accepts r_0. syn and syn_zero are stable in that same cycle.
- busy is registered:
  - it becomes 1 the cycle after the sof bit is accepted;
  - it becomes 0 in the same cycle that syn_valid is 1.
- frame_err is asserted in the cycle after the offending sof edge.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package bch31_pkg:
  - localparams N = 31, M = 5, PRIM_POLY = 5'b00101 (low terms of x^5+x^2+1);
  - typedef gf_elem_t = logic [M-1:0];
  - a constant function that returns the 5×5 bit matrix for multiply-by-α^j, used at elaboration.
- Sub-module bch31_syn_cell, parameter J:
  - holds one accumulator A_J and its constant multiplier;
  - inputs: load, step, bit;
  - instantiated 2T times with a generate loop.
- The top level owns cnt, busy, frame_err, and the output registers.

## Test plan
- All-zero codeword, 31 bits, sof on the first → syn_valid on cycle 32; all syn = 0; syn_zero = 1.
- Single 1 at r_0 (last bit), T=3 → S1..S6 = 1,1,1,1,1,1; syn_zero = 0.
- Single 1 at r_30 (first bit) → S1..S6 = 18,9,22,11,23,25 (α^30j).
- Single 1 at r_1 → S1..S6 = 2,4,8,16,5,10. Drive it back-to-back after the previous frame with no idle cycle → two syn_valid pulses exactly 31 cycles apart.
- sof asserted again at bit 10 of a frame → frame_err pulses once; the following 31 bits complete normally; syn reflects only the new frame.
- Random in_valid gaps plus an asynchronous rst pulse at bit 15:
  - all outputs clear immediately;
  - no syn_valid for the aborted frame;
  - stray non-sof bits while idle are ignored.
